// File: rtl/lcd_scan_ctrl.sv
// Raster scan controller for a parallel-RGB LCD: walks the frame, issues active-area
// coordinates and animation phase, and delays DE/HSYNC/VSYNC by the renderer latency.
module lcd_scan_ctrl #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 32,
  parameter int H_BP     = 40,
  parameter int H_SYNC   = 8,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 32,
  parameter int V_BP     = 16,
  parameter int V_SYNC   = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       px_valid,
  output logic [7:0] phase,
  output logic       frame_start,
  output logic       DE,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       busy
);

  localparam int H_TOTAL = H_FP + H_ACTIVE + H_BP;
  localparam int V_TOTAL = V_FP + V_ACTIVE + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_BEG    = 10'(H_FP);
  localparam logic [9:0] H_END    = 10'(H_FP + H_ACTIVE);
  localparam logic [9:0] V_BEG    = 10'(V_FP);
  localparam logic [9:0] V_END    = 10'(V_FP + V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_TOTAL - H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_TOTAL - V_SYNC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [8:0] fc_q, fc_d;

  logic       scanning;
  logic       last_px;

  assign scanning = (state_q != S_IDLE);
  assign last_px  = (x_q == H_LAST) && (y_q == V_LAST);

  // Stopping is only ever committed at the last pixel, so no frame is truncated.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en) state_d = last_px ? S_IDLE : S_STOP;
      end
      S_STOP: begin
        if (en)           state_d = S_RUN;
        else if (last_px) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    if (!scanning) begin
      x_d = 10'd0;
      y_d = 10'd0;
    end else if (x_q == H_LAST) begin
      x_d = 10'd0;
      if (y_q == V_LAST) begin
        y_d  = 10'd0;
        fc_d = fc_q + 9'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end else begin
      x_d = x_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      fc_q    <= 9'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
    end
  end

  // Registered view of the current scan position.
  logic       active;
  logic       px_valid_q, px_valid_d;
  logic [9:0] px_x_q, px_x_d;
  logic [9:0] px_y_q, px_y_d;
  logic [7:0] phase_q, phase_d;
  logic       fs_q, fs_d;
  logic       busy_q, busy_d;
  logic       hs_raw_q, hs_raw_d;
  logic       vs_raw_q, vs_raw_d;

  assign active = scanning &&
                  (x_q >= H_BEG) && (x_q < H_END) &&
                  (y_q >= V_BEG) && (y_q < V_END);

  // Phase folds the 9-bit frame count into a triangle so 255 repeats instead of wrapping.
  always_comb begin
    px_valid_d = active;
    px_x_d     = active ? (x_q - H_BEG) : 10'd0;
    px_y_d     = active ? (y_q - V_BEG) : 10'd0;
    fs_d       = scanning && (x_q == 10'd0) && (y_q == 10'd0);
    busy_d     = scanning;
    hs_raw_d   = ~(scanning && (x_q >= HS_START));
    vs_raw_d   = ~(scanning && (y_q >= VS_START));
    phase_d    = phase_q;
    if (fs_d) phase_d = fc_q[8] ? (8'd255 - fc_q[7:0]) : fc_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_valid_q <= 1'b0;
      px_x_q     <= 10'd0;
      px_y_q     <= 10'd0;
      phase_q    <= 8'd0;
      fs_q       <= 1'b0;
      busy_q     <= 1'b0;
      hs_raw_q   <= 1'b1;
      vs_raw_q   <= 1'b1;
    end else begin
      px_valid_q <= px_valid_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      phase_q    <= phase_d;
      fs_q       <= fs_d;
      busy_q     <= busy_d;
      hs_raw_q   <= hs_raw_d;
      vs_raw_q   <= vs_raw_d;
    end
  end

  assign px_valid    = px_valid_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign phase       = phase_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

  // Sync delay line; while idle the raw stage already carries the fill values.
  generate
    if (PIPE_LAT == 0) begin : g_direct
      assign DE    = px_valid_q;
      assign HSYNC = hs_raw_q;
      assign VSYNC = vs_raw_q;
    end else begin : g_delay
      logic [PIPE_LAT-1:0] de_sr_q;
      logic [PIPE_LAT-1:0] hs_sr_q;
      logic [PIPE_LAT-1:0] vs_sr_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          de_sr_q <= '0;
          hs_sr_q <= '1;
          vs_sr_q <= '1;
        end else begin
          de_sr_q[0] <= px_valid_q;
          hs_sr_q[0] <= hs_raw_q;
          vs_sr_q[0] <= vs_raw_q;
          for (int i = 1; i < PIPE_LAT; i++) begin
            de_sr_q[i] <= de_sr_q[i-1];
            hs_sr_q[i] <= hs_sr_q[i-1];
            vs_sr_q[i] <= vs_sr_q[i-1];
          end
        end
      end

      assign DE    = de_sr_q[PIPE_LAT-1];
      assign HSYNC = hs_sr_q[PIPE_LAT-1];
      assign VSYNC = vs_sr_q[PIPE_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Bench for lcd_scan_ctrl with a small 8x5 raster, PIPE_LAT=2 and PIPE_LAT=0 instances.
module tb_lcd_scan_ctrl;

  localparam int HA = 4, HF = 2, HB = 2, HS = 1;
  localparam int VA = 3, VF = 1, VB = 1, VS = 1;
  localparam int HT = HF + HA + HB;
  localparam int VT = VF + VA + VB;

  logic clk, rst_n, en;

  logic [9:0] px_x2, px_y2, px_x0, px_y0;
  logic       px_valid2, px_valid0;
  logic [7:0] phase2, phase0;
  logic       fs2, fs0, de2, de0, hs2, hs0, vs2, vs0, busy2, busy0;

  lcd_scan_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_BP(HB), .H_SYNC(HS),
                  .V_ACTIVE(VA), .V_FP(VF), .V_BP(VB), .V_SYNC(VS), .PIPE_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .px_x(px_x2), .px_y(px_y2), .px_valid(px_valid2), .phase(phase2),
    .frame_start(fs2), .DE(de2), .HSYNC(hs2), .VSYNC(vs2), .busy(busy2)
  );

  lcd_scan_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_BP(HB), .H_SYNC(HS),
                  .V_ACTIVE(VA), .V_FP(VF), .V_BP(VB), .V_SYNC(VS), .PIPE_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .px_x(px_x0), .px_y(px_y0), .px_valid(px_valid0), .phase(phase0),
    .frame_start(fs0), .DE(de0), .HSYNC(hs0), .VSYNC(vs0), .busy(busy0)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q entry: {frame_start, busy, px_valid, px_x, px_y, phase, sync_lat2, sync_lat0}
  logic [36:0] exp_q[$];
  logic [19:0] coord_q[$];
  logic [7:0]  phase_q[$];

  int         m_state;   // 0 idle, 1 run, 2 stop
  int         m_x, m_y, m_fc;
  logic [7:0] m_phase;
  logic [2:0] h1, h2;    // {de, hs, vs} raw history

  always @(posedge clk) begin
    logic m_busy, m_act, m_fs, m_last;
    logic [9:0] ex, ey;
    logic [2:0] raw;
    if (!rst_n) begin
      m_state = 0; m_x = 0; m_y = 0; m_fc = 0; m_phase = 8'd0;
      h1 = 3'b011; h2 = 3'b011;
      exp_q.delete();
    end else begin
      m_busy = (m_state != 0);
      m_act  = m_busy && m_x >= HF && m_x < HF + HA && m_y >= VF && m_y < VF + VA;
      m_fs   = m_busy && m_x == 0 && m_y == 0;
      if (m_fs) m_phase = (m_fc < 256) ? 8'(m_fc) : 8'(511 - m_fc);
      ex  = m_act ? 10'(m_x - HF) : 10'd0;
      ey  = m_act ? 10'(m_y - VF) : 10'd0;
      raw = {m_act, !(m_busy && m_x >= HT - HS), !(m_busy && m_y >= VT - VS)};
      exp_q.push_back({m_fs, m_busy, m_act, ex, ey, m_phase, h2, raw});
      h2 = h1;
      h1 = raw;
      m_last = (m_x == HT - 1) && (m_y == VT - 1);
      if (m_busy) begin
        if (m_last) m_fc = (m_fc + 1) % 512;
        m_x = (m_x + 1) % HT;
        if (m_x == 0) m_y = (m_y + 1) % VT;
      end
      case (m_state)
        0: if (en) m_state = 1;
        1: if (!en) m_state = m_last ? 0 : 2;
        default: if (en) m_state = 1; else if (m_last) m_state = 0;
      endcase
    end
  end

  // ---------------- scoreboard / per-cycle checks ----------------
  int cyc = 0;
  int prev_fs = -1;
  int de_len = 0;
  int hs_len = 0;

  always @(negedge clk) begin
    logic [36:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("outs_lat2", {fs2, busy2, px_valid2, px_x2, px_y2, phase2}, e[36:6]);
      check_eq("outs_lat0", {fs0, busy0, px_valid0, px_x0, px_y0, phase0}, e[36:6]);
      check_eq("sync_lat2", {de2, hs2, vs2}, e[5:3]);
      check_eq("sync_lat0", {de0, hs0, vs0}, e[2:0]);
    end
    if (!rst_n) begin
      prev_fs = -1; de_len = 0; hs_len = 0;
    end else begin
      if (px_valid2 && coord_q.size() > 0) check_eq("coord", {px_x2, px_y2}, coord_q.pop_front());
      if (fs2 && phase_q.size() > 0) check_eq("phase_seq", phase2, phase_q.pop_front());
      if (fs2) begin
        if (prev_fs >= 0) check_eq("fs_gap", cyc - prev_fs, HT * VT);
        prev_fs = cyc;
      end else if (!busy2) begin
        prev_fs = -1;
      end
      if (de2) de_len++;
      else if (de_len > 0) begin
        check_eq("de_width", de_len, HA);
        de_len = 0;
      end
      if (!hs2) hs_len++;
      else if (hs_len > 0) begin
        check_eq("hs_width", hs_len, HS);
        hs_len = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pos(input int x, input int y);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(m_state != 0 && m_x == x && m_y == y) && g < 200);
    check_eq("wait_pos", (g < 200), 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int g;
    int fs_cnt;
    rst_n = 1'b0;
    en    = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int yy = 0; yy < VA; yy++)
        for (int xx = 0; xx < HA; xx++) coord_q.push_back({10'(xx), 10'(yy)});
    for (int i = 0; i < 256; i++) phase_q.push_back(8'(i));
    for (int i = 255; i >= 0; i--) phase_q.push_back(8'(i));
    phase_q.push_back(8'd0);

    @(negedge clk);
    check_eq("rst_outs", {fs2, busy2, px_valid2, px_x2, px_y2, phase2}, 31'd0);
    check_eq("rst_sync", {de2, hs2, vs2}, 3'b011);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    // continuous run: raster, widths, gaps and the full 512-frame phase triangle
    en = 1'b1;
    g = 0;
    while (phase_q.size() > 0 && g < 25000) begin
      @(negedge clk);
      g++;
    end
    check_eq("phase_done", phase_q.size(), 0);
    check_eq("coord_done", coord_q.size(), 0);

    // drop en at (3,2): frame completes, busy falls, syncs drain
    wait_pos(3, 2);
    en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy2 && n < 100);
    check_eq("busy_fall", n, (HT * VT - (2 * HT + 3)) + 1);
    idle_cycles(2);
    check_eq("drain", {de2, hs2, vs2}, 3'b011);
    fs_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (fs2) fs_cnt++;
    end
    check_eq("idle_fs", fs_cnt, 0);

    // en dropped then reasserted during STOP: no gap between frames
    en = 1'b1;
    wait_pos(5, 1);
    en = 1'b0;
    idle_cycles(8);
    en = 1'b1;
    idle_cycles(100);

    // async reset mid-line
    wait_pos(4, 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_outs", {fs2, busy2, px_valid2, px_x2, px_y2, phase2}, 31'd0);
    check_eq("arst_sync2", {de2, hs2, vs2}, 3'b011);
    check_eq("arst_sync0", {de0, hs0, vs0}, 3'b011);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs2 && n < 10);
    check_eq("fs_after_rst", n, 2);
    check_eq("phase_after_rst", phase2, 8'd0);
    idle_cycles(90);

    // final stop
    en = 1'b0;
    idle_cycles(2 * HT * VT);
    check_eq("final_idle", {busy2, de2, hs2, vs2}, 4'b0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_scan_ctrl.md
# lcd_scan_ctrl

Raster scan controller for the 480x272 parallel-RGB LCD panel. It sequences the pixel datapath: it walks the frame, issues active-area pixel coordinates and an animation phase to the per-pixel renderer, and delays DE/HSYNC/VSYNC by the renderer's pipeline latency so that sync and data reach the panel pins together. Start and stop are gated to frame boundaries, so the panel never sees a truncated frame.

## Interface
- H_ACTIVE, 480, active pixels per line
- H_FP, 32, horizontal front porch (clocks before active)
- H_BP, 40, horizontal back porch (clocks after active)
- H_SYNC, 8, HSYNC low width, at end of line
- V_ACTIVE, 272, active lines per frame
- V_FP, 32, vertical front porch (lines)
- V_BP, 16, vertical back porch (lines)
- V_SYNC, 8, VSYNC low width, at end of frame (lines)
- PIPE_LAT, 2, renderer latency in clocks (0..15)

- clk  in  1  pixel clock, also drives DCLK (12 MHz max)
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run request, level
- px_x  out  10  active-relative column, 0..H_ACTIVE-1
- px_y  out  10  active-relative row, 0..V_ACTIVE-1
- px_valid  out  1  px_x/px_y are inside the active area
- phase  out  8  triangle-wave animation phase, constant within a frame
- frame_start  out  1  one-cycle pulse at scan position (0,0)
- DE  out  1  data enable, delayed PIPE_LAT
- HSYNC  out  1  active-low, delayed PIPE_LAT
- VSYNC  out  1  active-low, delayed PIPE_LAT
- busy  out  1  high in RUN or STOP

## Operation
- H_TOTAL = H_FP+H_ACTIVE+H_BP. V_TOTAL = V_FP+V_ACTIVE+V_BP.
- Counters: x counts 0..H_TOTAL-1 and wraps. y increments on x wrap and counts 0..V_TOTAL-1.
- Active area: H_FP <= x < H_FP+H_ACTIVE and V_FP <= y < V_FP+V_ACTIVE.
  - In the active area: px_valid=1, px_x=x-H_FP, px_y=y-V_FP.
  - Outside it: px_valid=0 and px_x/px_y are forced to 0.
- Raw syncs:
  - hs = ~(x >= H_TOTAL-H_SYNC).
  - vs = ~(y >= V_TOTAL-V_SYNC).
  - de = px_valid.
- Each raw sync passes through a PIPE_LAT-deep shift register. PIPE_LAT=0 means a direct path.
- Shift-register fill values: de=0, hs=1, vs=1. Registers load these on reset and while IDLE.
- Frame counter fc, 9 bits:
  - Increments at the last pixel of each RUN/STOP frame (x=H_TOTAL-1, y=V_TOTAL-1).
  - Wraps 511->0.
  - phase = fc[8] ? 8'd255-fc[7:0] : fc[7:0], giving 0..255..0 with no glitch at 256.
- State machine:
  - IDLE: x=y=0, outputs idle. en=1 -> RUN.
  - RUN: scanning. en=0 -> STOP.
  - STOP: scanning. At the last pixel of the frame, go to IDLE if en=0. If en=1 at that point (or earlier), return to RUN. The scan is not interrupted.
  - On the IDLE->RUN transition, scanning starts at (0,0) on the first RUN cycle.
- frame_start = (state!=IDLE) & x==0 & y==0. It is not delayed.
- busy = (state!=IDLE).

## Timing
- Reset values (async, all registers): state=IDLE, x=y=0, fc=0, phase=0, px_x=px_y=0, px_valid=0, frame_start=0, DE=0, HSYNC=1, VSYNC=1, busy=0.
- rst_n deasserting mid-frame aborts the scan immediately. No drain.
- px_x, px_y, px_valid, phase and frame_start are registered outputs describing scan position (x,y) of the current cycle. Renderer output for that position is due PIPE_LAT cycles later.
- DE/HSYNC/VSYNC at cycle t equal the raw values of cycle t-PIPE_LAT.
- en sampled high at edge k in IDLE: busy=1 and frame_start=1 from edge k+1.
- After the final STOP frame, IDLE begins on the following cycle. The delayed syncs then drain to idle within PIPE_LAT cycles, because the IDLE fill shifts in.
- phase changes only on the cycle where frame_start is asserted.

## Test plan
- Small params (H_ACTIVE=4, H_FP=2, H_BP=2, H_SYNC=1, V_ACTIVE=3, V_FP=1, V_BP=1, V_SYNC=1, PIPE_LAT=2), en=1 -> frame_start every 40 clocks. 12 px_valid pulses per frame, with (px_x,px_y) running (0,0)..(3,2) in raster order. DE pulses are 4 clocks wide and lag px_valid by exactly 2. HSYNC is low 1 clock per 8.
- Same params, run 512 frames -> phase sequence 0,1,...,255,255,254,...,0, then repeats from 0.
- en dropped mid-frame at x=3,y=2 -> frame completes, busy falls one cycle after (7,4). DE/HSYNC/VSYNC reach 0/1/1 two cycles later. No further frame_start.
- en dropped, then reasserted during STOP -> no gap: frame_start appears 40 clocks after the previous one.
- rst_n pulsed low mid-line -> all outputs take reset values asynchronously, within the same cycle. With en=1 after release, frame_start asserts one cycle after the first clk edge.
- PIPE_LAT=0 -> DE identical to px_valid every cycle.
